// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared constants and the read-issue decision for the FIFO read side.
package fifo_rd_ctrl_pkg;

  // Default storage depth (power of 2, >= 2) and word width.
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 8;

  // Output skid buffer depth. Fixed: the issue rule below is written for exactly 2.
  localparam int SKID_DEPTH = 2;

  // A read may be issued when the FIFO holds data and the words already
  // buffered plus the one in flight leave room, or a pop this cycle frees a slot.
  function automatic logic can_issue(input logic       empty,
                                     input logic [1:0] buf_cnt,
                                     input logic       infl,
                                     input logic       pop);
    logic [2:0] occ;
    occ = {1'b0, buf_cnt} + {2'b00, infl};
    return ~empty & ((occ < 3'(SKID_DEPTH)) | ((occ == 3'(SKID_DEPTH)) & pop));
  endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry register buffer holding words returned by the memory until the
// consumer takes them. Entry 0 is always the head.
module fifo_out_skid
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            cnt_o
);

  logic [DATA_WIDTH-1:0] e0_q, e0_d;
  logic [DATA_WIDTH-1:0] e1_q, e1_d;
  logic [1:0]            cnt_q, cnt_d;

  // Next-state of the two entries and the occupancy count.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = data_i;
        else               e1_d = data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        // Count is unchanged; the new word lands behind whatever remains.
        if (cnt_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = data_i;
        end else begin
          e0_d = data_i;
        end
      end
      default: ;
    endcase
  end

  // Buffer state register; cleared on reset so no stale word survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign data_o = e0_q;
  assign cnt_o  = cnt_q;

  skid_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push_i && (cnt_q == 2'd2)));

  skid_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(pop_i && (cnt_q == 2'd0)));

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the sync FIFO: owns the read pointer, issues reads
// to 1-cycle-latency memory and hands words to the consumer via a skid buffer.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_empty,
  output logic [ADDR_WIDTH:0]   o_rd_addr,
  output logic                  o_mem_rd_en,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
  output logic                  o_valid_m,
  input  logic                  i_ready_m,
  output logic [DATA_WIDTH-1:0] o_data_m,
  output logic [1:0]            o_buf_cnt
);

  logic [ADDR_WIDTH:0] rd_addr_q, rd_addr_d;
  logic                infl_q, infl_d;
  logic                pop;
  logic                rd_en;
  logic [1:0]          buf_cnt;

  assign o_valid_m = (buf_cnt != 2'd0);
  assign pop       = o_valid_m & i_ready_m;

  // Issue decision and pointer advance; the wrap bit falls out of the
  // natural modulo-2*FIFO_DEPTH overflow of the extra pointer bit.
  always_comb begin
    rd_en     = can_issue(i_empty, buf_cnt, infl_q, pop);
    rd_addr_d = rd_addr_q + {{ADDR_WIDTH{1'b0}}, rd_en};
    infl_d    = rd_en;
  end

  // Pointer and in-flight flag; reset drops any outstanding read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr_q <= '0;
      infl_q    <= 1'b0;
    end else begin
      rd_addr_q <= rd_addr_d;
      infl_q    <= infl_d;
    end
  end

  // Memory data returns one cycle after the strobe, which is exactly when infl_q is set.
  fifo_out_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (infl_q),
    .data_i  (i_mem_rd_data),
    .pop_i   (pop),
    .data_o  (o_data_m),
    .cnt_o   (buf_cnt)
  );

  assign o_rd_addr   = rd_addr_q;
  assign o_mem_rd_en = rd_en;
  assign o_buf_cnt   = buf_cnt;

endmodule
